if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage plus IF/ID pipeline register; directly upstream of the decode stage, which it drives with a registered PC and instruction.
- Holds the program counter.
- Reads a word-addressed instruction memory, loadable from the bench/loader through a write port.
- Applies branch redirect and flush from EXE, and hazard freeze from the hazard unit.
- Keeps a retired-fetch counter for performance checks.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two, >=2)
IMEM_AW, 6, word-address width, equals log2(IMEM_WORDS)
OOR_WORD, 32'h00000000, word returned for fetch addresses beyond memory

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
freeze  in  1  hazard stall from hazard unit; hold PC and IF/ID register
branch_taken  in  1  branch resolved taken in EXE; redirect PC and flush IF/ID
branch_addr  in  32  branch target byte address
imem_we  in  1  instruction memory write enable
imem_waddr  in  IMEM_AW  instruction memory write word address
imem_wdata  in  32  instruction memory write data
pc_out  out  32  registered PC+4 of the fetched instruction, to decode
instruction_out  out  32  registered instruction, to decode
valid_out  out  1  IF/ID slot holds a real fetched instruction
pc_current  out  32  current fetch PC (debug/visibility)
fetch_count  out  32  count of instructions loaded into IF/ID

Behaviour:
Clock and reset:
- One clock (clk). rst is synchronous and active-high; it is sampled only at the rising edge of clk and has priority over every other input.
- Reset values: pc_current=0, pc_out=0, instruction_out=0, valid_out=0, fetch_count=0. Memory contents are not cleared by reset.

PC register update (priority order per edge: rst > branch_taken > freeze > advance):
- branch_taken=1: pc <= {branch_addr[31:2],2'b00}. Low two bits are forced to zero; misaligned targets are silently aligned.
- freeze=1 (no branch): pc holds.
- Otherwise: pc <= pc+4, modulo 2^32. 32'hFFFFFFFC wraps to 0.

Fetch (combinational from pc_current):
- Word index = pc_current[IMEM_AW+1:2].
- If pc_current[31:IMEM_AW+2] != 0, the fetched word is OOR_WORD.

IF/ID register (same priority):
- branch_taken=1: flush. pc_out <= 0, instruction_out <= 0, valid_out <= 0. This also applies when freeze=1 in the same cycle.
- freeze=1: pc_out, instruction_out and valid_out hold.
- Otherwise: pc_out <= pc_current+4, instruction_out <= fetched word, valid_out <= 1.

fetch_count:
- Increments by 1 (wrapping at 2^32) exactly on edges where the IF/ID register loads (advance case only).
- Unchanged on freeze, flush and reset-release edge.

Instruction memory write:
- When imem_we=1, mem[imem_waddr] <= imem_wdata at the rising edge.
- Writes are accepted during rst, freeze or branch.
- A fetch at the same edge to the same address captures the pre-write contents; new data is visible from the next cycle.

Latency:
- Instruction at address A appears on instruction_out one cycle after pc_current=A, absent freeze.
- After a taken branch, the target instruction reaches instruction_out two edges after branch_taken is sampled, with one flushed bubble (valid_out=0) in between.

Reset mid-operation:
- All architectural state returns to its reset values on the reset edge.
- Fetch resumes from address 0 on the first edge after rst deasserts.

Test Plan:
- Load mem[0..3]=32'hE3A01001,32'hE3A02002,32'hE0813002,32'hE1A00000; rst 2 cycles, release, run 4 cycles -> instruction_out follows the four words in order; pc_out = 4,8,12,16; valid_out=1; fetch_count=4.
- freeze=1 for 3 cycles while pc_current=8 -> pc_current stays 8; pc_out=8 and instruction_out=32'hE3A02002 held; fetch_count unchanged; on release, next load gives pc_out=12.
- branch_taken=1 with branch_addr=32'h00000022 and freeze=1 in the same cycle -> pc_current=32'h20 next edge; IF/ID flushed (valid_out=0, instruction_out=0); following edge loads mem[8] with pc_out=32'h24.
- Branch to 32'h00000400 with IMEM_WORDS=64 -> instruction_out=OOR_WORD after one cycle; pc_out=32'h404.
- Branch to 32'hFFFFFFFC, then advance -> pc_current wraps to 0; next instruction_out=mem[0].
- Write mem[5]=32'hDEADBEEF on the same edge that fetches word 5 -> instruction_out shows the old word; a later re-fetch of address 20 shows 32'hDEADBEEF.
- Assert rst mid-run with fetch_count=7 -> all outputs return to 0 on that edge; memory contents retained.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a loader write port, and the IF/ID pipeline register feeding decode.
module if_fetch_unit #(
    parameter int          IMEM_WORDS = 64,
    parameter int          IMEM_AW    = 6,
    parameter logic [31:0] OOR_WORD   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic [31:0]        pc_out,
    output logic [31:0]        instruction_out,
    output logic               valid_out,
    output logic [31:0]        pc_current,
    output logic [31:0]        fetch_count
);

    logic [31:0] mem_r [IMEM_WORDS];
    logic [31:0] pc_r;
    logic [31:0] pc_out_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic [31:0] count_r;
    logic [31:0] fetch_word_s;
    logic [31:0] pc_next_s;
    logic        out_of_range_s;
    logic        unused_s;

    // Branch targets are word-aligned by dropping the two low address bits.
    assign unused_s = ^branch_addr[1:0];

    assign pc_next_s      = pc_r + 32'd4;
    assign out_of_range_s = (pc_r[31:IMEM_AW+2] != '0);

    // Combinational fetch; addresses past the end of memory read as OOR_WORD.
    always_comb begin
        fetch_word_s = OOR_WORD;
        if (out_of_range_s) begin
            fetch_word_s = OOR_WORD;
        end else begin
            fetch_word_s = mem_r[pc_r[IMEM_AW+1:2]];
        end
    end

    // Loader write port; never cleared by reset and active in every pipeline state.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_r[imem_waddr] <= imem_wdata;
        end
    end

    // PC, IF/ID register and retired-fetch counter: rst > branch > freeze > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= 32'h0000_0000;
            pc_out_r <= 32'h0000_0000;
            instr_r  <= 32'h0000_0000;
            valid_r  <= 1'b0;
            count_r  <= 32'h0000_0000;
        end else if (branch_taken) begin
            pc_r     <= {branch_addr[31:2], 2'b00};
            pc_out_r <= 32'h0000_0000;
            instr_r  <= 32'h0000_0000;
            valid_r  <= 1'b0;
        end else if (freeze) begin
            pc_r     <= pc_r;
            pc_out_r <= pc_out_r;
            instr_r  <= instr_r;
            valid_r  <= valid_r;
        end else begin
            pc_r     <= pc_next_s;
            pc_out_r <= pc_next_s;
            instr_r  <= fetch_word_s;
            valid_r  <= 1'b1;
            count_r  <= count_r + 32'd1;
        end
    end

    assign pc_current      = pc_r;
    assign pc_out          = pc_out_r;
    assign instruction_out = instr_r;
    assign valid_out       = valid_r;
    assign fetch_count     = count_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit: each record holds one cycle's
// inputs and the hand-computed IF state expected after that rising edge.
module tb_if_fetch_unit;

    localparam logic [31:0] OOR = 32'h0BAD_0BAD;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic [31:0] pc_current;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.IMEM_WORDS(64), .IMEM_AW(6), .OOR_WORD(OOR)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .pc_out(pc_out), .instruction_out(instruction_out),
        .valid_out(valid_out), .pc_current(pc_current), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] baddr;
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_pc;
        logic [31:0] e_pco;
        logic [31:0] e_ins;
        logic        e_v;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba,
                                logic w, logic [5:0] wa, logic [31:0] wd,
                                logic [31:0] pc, logic [31:0] pco, logic [31:0] ins,
                                logic v, logic [31:0] cnt);
        vec_t t;
        t.rst = r; t.frz = f; t.br = b; t.baddr = ba;
        t.we = w; t.waddr = wa; t.wdata = wd;
        t.e_pc = pc; t.e_pco = pco; t.e_ins = ins; t.e_v = v; t.e_cnt = cnt;
        return t;
    endfunction

    function automatic logic [31:0] init_word(int i);
        logic [31:0] w;
        case (i)
            0:       w = 32'hE3A0_1001;
            1:       w = 32'hE3A0_2002;
            2:       w = 32'hE081_3002;
            3:       w = 32'hE1A0_0000;
            default: w = 32'hA000_0000 | 32'(i);
        endcase
        return w;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(string tag, logic [31:0] pc, logic [31:0] pco,
                             logic [31:0] ins, logic v, logic [31:0] cnt);
        chk({tag, " pc_current"}, pc_current, pc);
        chk({tag, " pc_out"}, pc_out, pco);
        chk({tag, " instruction_out"}, instruction_out, ins);
        chk({tag, " valid_out"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, " fetch_count"}, fetch_count, cnt);
    endtask

    task automatic step(logic r, logic f, logic b, logic [31:0] ba,
                        logic w, logic [5:0] wa, logic [31:0] wd);
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_addr = ba;
        imem_we = w; imem_waddr = wa; imem_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        imem_we = 1'b0; imem_waddr = 6'd0; imem_wdata = 32'd0;

        // Load memory while held in reset
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 6'(i), init_word(i));
        end
        chk_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        //             rst   frz   br    baddr          we    wa     wdata          pc             pc_out         instr           v     cnt
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h4,         32'h4,         32'hE3A0_1001, 1'b1, 32'd1);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h8,         32'h8,         32'hE3A0_2002, 1'b1, 32'd2);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'hC,         32'hC,         32'hE081_3002, 1'b1, 32'd3);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h10,        32'h10,        32'hE1A0_0000, 1'b1, 32'd4);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h4,         1'b0, 6'd0, 32'd0,         32'h4,         32'h0,         32'h0,         1'b0, 32'd4);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h8,         32'h8,         32'hE3A0_2002, 1'b1, 32'd5);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h8,         32'h8,         32'hE3A0_2002, 1'b1, 32'd5);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h8,         32'h8,         32'hE3A0_2002, 1'b1, 32'd5);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h8,         32'h8,         32'hE3A0_2002, 1'b1, 32'd5);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'hC,         32'hC,         32'hE081_3002, 1'b1, 32'd6);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h22,        1'b0, 6'd0, 32'd0,         32'h20,        32'h0,         32'h0,         1'b0, 32'd6);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h24,        32'h24,        32'hA000_0008, 1'b1, 32'd7);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h0,         32'h0,         32'h0,         1'b0, 32'd0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h4,         32'h4,         32'hE3A0_1001, 1'b1, 32'd1);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h400,       1'b0, 6'd0, 32'd0,         32'h400,       32'h0,         32'h0,         1'b0, 32'd1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h404,       32'h404,       OOR,           1'b1, 32'd2);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 6'd0, 32'd0,         32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0, 32'd2);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h0,         32'h0,         OOR,           1'b1, 32'd3);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h4,         32'h4,         32'hE3A0_1001, 1'b1, 32'd4);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'h14,        1'b0, 6'd0, 32'd0,         32'h14,        32'h0,         32'h0,         1'b0, 32'd4);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b1, 6'd5, 32'hDEAD_BEEF, 32'h18,        32'h18,        32'hA000_0005, 1'b1, 32'd5);
        vecs[21] = mk(1'b0, 1'b0, 1'b1, 32'h14,        1'b0, 6'd0, 32'd0,         32'h14,        32'h0,         32'h0,         1'b0, 32'd5);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h18,        32'h18,        32'hDEAD_BEEF, 1'b1, 32'd6);
        vecs[23] = mk(1'b1, 1'b0, 1'b1, 32'h40,        1'b0, 6'd0, 32'd0,         32'h0,         32'h0,         32'h0,         1'b0, 32'd0);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 6'd0, 32'd0,         32'h4,         32'h4,         32'hE3A0_1001, 1'b1, 32'd1);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].baddr,
                 vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pco,
                      vecs[i].e_ins, vecs[i].e_v, vecs[i].e_cnt);
        end

        // Memory write accepted during freeze; the frozen PC then fetches the new word
        step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 6'd1, 32'h1111_2222);
        chk_state("frzwr hold", 32'h4, 32'h4, 32'hE3A0_1001, 1'b1, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
        chk_state("frzwr fetch", 32'h8, 32'h8, 32'h1111_2222, 1'b1, 32'd2);

        // Write during reset lands in memory and reset leaves other words intact
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 32'h5555_AAAA);
        chk_state("rstwr reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
        chk_state("rstwr w0", 32'h4, 32'h4, 32'h5555_AAAA, 1'b1, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
        chk_state("rstwr w1", 32'h8, 32'h8, 32'h1111_2222, 1'b1, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
